ofifo_collector: RTL and testbench

Output collection buffer directly downstream of the 8×8 `mac_array`. It accepts the per-column partial sums on `out_s` at the cycle each column raises its `valid` bit. Because the array output is skewed, column *c* produces its result one cycle after column *c-1*. The block re-aligns these column results into complete rows and presents them one row at a time to the psum/SFU stage, under a valid/read handshake.

---
 rtl/ofifo_collector.sv | 101 ++++++++++
 tb/tb_ofifo_collector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_collector.sv
// ofifo_collector: re-aligns skewed per-column partial sums from the MAC array into full rows.
// Latency: a write is visible in the lane count after its edge; an accepted read updates out 1 cycle later.
// Backpressure: o_valid gates reads; writes to a full lane are dropped (sticky o_overflow) unless a read pops the same cycle.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   in  / wr        - per-lane data and write strobes (lane c = in[psum_bw*c +: psum_bw])
//   rd              - row read request, accepted only while o_valid
//   out             - registered row, same lane ordering as in, holds until the next accepted read
//   o_valid/o_ready/o_full/o_overflow - row available / all lanes have room / some lane full / dropped write seen
module ofifo_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(depth);

  logic [col-1:0]         nonempty;
  logic [col-1:0]         full;
  logic [col-1:0]         wr_acc;
  logic                   rd_acc;
  logic [col*psum_bw-1:0] out_q, out_d;
  logic                   ovf_q, ovf_d;

  // All lanes pop together, and only when every lane holds an entry.
  assign rd_acc = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_lane
    logic [psum_bw-1:0] mem_q [depth];
    logic [AW-1:0]      wp_q, wp_d;
    logic [AW-1:0]      rp_q, rp_d;
    logic [AW:0]        cnt_q, cnt_d;

    assign full[c]     = (cnt_q == DEPTH_CNT);
    assign nonempty[c] = (cnt_q != '0);
    // A full lane can still take a write when the same edge pops its head.
    assign wr_acc[c]   = wr[c] & (~full[c] | rd_acc);

    always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (wr_acc[c]) wp_d = wp_q + 1'b1;
      if (rd_acc)    rp_d = rp_q + 1'b1;
      if (wr_acc[c] && !rd_acc)      cnt_d = cnt_q + 1'b1;
      else if (!wr_acc[c] && rd_acc) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
      end
    end

    // Storage needs no reset: counts gate every read of it.
    always_ff @(posedge clk) begin
      if (!reset && wr_acc[c]) mem_q[wp_q] <= in[c*psum_bw +: psum_bw];
    end

    // When full, wp == rp: the head is read before this edge's write lands.
    assign out_d[c*psum_bw +: psum_bw] = rd_acc ? mem_q[rp_q] : out_q[c*psum_bw +: psum_bw];
  end

  assign ovf_d = ovf_q | (|(wr & ~wr_acc));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out        = out_q;
  assign o_overflow = ovf_q;
  assign o_valid    = &nonempty;
  assign o_full     = |full;
  assign o_ready    = ~o_full;

endmodule

// File: tb/tb_ofifo_collector.sv
// tb_ofifo_collector: directed checks of ofifo_collector row alignment, full/overflow and wrap behaviour.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Expected rows are built from the stimulus formulas, never read back from the design.
module tb_ofifo_collector;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int W   = COL*BW;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic [COL-1:0] wr;
  logic         rd;
  logic [W-1:0] out;
  logic         o_valid, o_ready, o_full, o_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  ofifo_collector #(.col(COL), .psum_bw(BW), .depth(64)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lane c = row*16 + c
  function automatic logic [W-1:0] row_val(input int r);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = 16'(r*16 + c);
    return v;
  endfunction

  // lane c = c*256 + i
  function automatic logic [W-1:0] fill_val(input int i);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = 16'(c*256 + i);
    return v;
  endfunction

  function automatic logic [W-1:0] base_val(input int base);
    logic [W-1:0] v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = 16'(base + c);
    return v;
  endfunction

  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] new_v;
    int w, rrow, mcnt;
    bit do_wr, do_rd, acc;

    reset = 1'b1; in = '0; wr = '0; rd = 1'b0;
    #1;
    tick();
    chk("reset_out", out, '0);
    chk("reset_ovf", W'(o_overflow), W'(0));
    tick();
    reset = 1'b0;
    chk("reset_valid", W'(o_valid), W'(0));
    chk("reset_ready", W'(o_ready), W'(1));
    chk("reset_full",  W'(o_full),  W'(0));

    // Skewed single row: lane c written at cycle c.
    for (int c = 0; c < COL; c++) begin
      wr = '0; wr[c] = 1'b1;
      in = '0; in[c*BW +: BW] = 16'(16'h0100 + c);
      tick();
      chk($sformatf("t1_valid_lane%0d", c), W'(o_valid), W'(c == COL-1));
    end
    wr = '0; rd = 1'b1;
    tick();
    chk("t1_out", out, base_val(16'h0100));
    chk("t1_valid_after", W'(o_valid), W'(0));
    rd = 1'b0;

    // Three skewed rows, then three back-to-back reads.
    for (int t = 0; t < 10; t++) begin
      wr = '0; in = '0;
      for (int c = 0; c < COL; c++) begin
        if (t - c >= 0 && t - c < 3) begin
          wr[c] = 1'b1;
          in[c*BW +: BW] = 16'((t - c)*16 + c);
        end
      end
      tick();
    end
    wr = '0;
    chk("t2_valid_before", W'(o_valid), W'(1));
    rd = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("t2_row%0d", r), out, row_val(r));
    end
    rd = 1'b0;
    chk("t2_valid_after", W'(o_valid), W'(0));

    // All lanes full, then simultaneous read + write.
    wr = '1;
    for (int i = 0; i < 64; i++) begin
      in = fill_val(i);
      tick();
    end
    chk("t4_full",  W'(o_full),  W'(1));
    chk("t4_ready", W'(o_ready), W'(0));
    chk("t4_valid", W'(o_valid), W'(1));
    new_v = base_val(16'hA000);
    in = new_v; rd = 1'b1;
    tick();
    chk("t4_out_oldest", out, fill_val(0));
    chk("t4_full_kept", W'(o_full), W'(1));
    chk("t4_ovf_zero", W'(o_overflow), W'(0));
    wr = '0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp_v = (k < 64) ? fill_val(k) : new_v;
      chk($sformatf("t4_drain%0d", k), out, exp_v);
    end
    rd = 1'b0;
    chk("t4_valid_empty", W'(o_valid), W'(0));
    chk("t4_ovf_end", W'(o_overflow), W'(0));

    // Lane 0 fill to 64, then a dropped 65th write.
    wr = 8'h01; in = '0;
    for (int i = 0; i < 64; i++) begin
      in[BW-1:0] = 16'(16'h5000 + i);
      tick();
    end
    chk("t3_full",  W'(o_full),  W'(1));
    chk("t3_ready", W'(o_ready), W'(0));
    chk("t3_ovf_before", W'(o_overflow), W'(0));
    in[BW-1:0] = 16'hDEAD;
    tick();
    chk("t3_ovf_set", W'(o_overflow), W'(1));
    chk("t3_full_kept", W'(o_full), W'(1));

    // Lanes 0..6 hold data, lane 7 empty: read ignored.
    wr = 8'h7E; in = base_val(16'h6000);
    tick();
    wr = '0; rd = 1'b1;
    tick();
    chk("t5_out_unchanged", out, new_v);
    chk("t5_valid_low", W'(o_valid), W'(0));
    rd = 1'b0; wr = 8'h80;
    tick();
    wr = '0;
    chk("t5_valid_rise", W'(o_valid), W'(1));
    rd = 1'b1;
    tick();
    rd = 1'b0;
    exp_v = base_val(16'h6000);
    exp_v[BW-1:0] = 16'h5000;
    chk("t5_row", out, exp_v);
    chk("t5_full_cleared", W'(o_full), W'(0));
    chk("t5_valid_after", W'(o_valid), W'(0));
    chk("t5_ovf_sticky", W'(o_overflow), W'(1));

    // Reset with rows stored and overflow set; wr/rd held active during reset.
    wr = '1;
    for (int i = 0; i < 5; i++) begin
      in = row_val(i);
      tick();
    end
    chk("t6_valid_before", W'(o_valid), W'(1));
    rd = 1'b1; reset = 1'b1;
    tick();
    chk("t6_valid", W'(o_valid), W'(0));
    chk("t6_ovf",   W'(o_overflow), W'(0));
    chk("t6_out",   out, '0);
    chk("t6_full",  W'(o_full), W'(0));
    chk("t6_ready", W'(o_ready), W'(1));
    tick();
    chk("t6_valid_hold", W'(o_valid), W'(0));
    reset = 1'b0; wr = '0; rd = 1'b0;

    // 200 rows streamed with interleaved reads; pointers wrap several times.
    w = 0; rrow = 0; mcnt = 0;
    for (int t = 0; t < 2000 && rrow < 200; t++) begin
      do_wr = (w < 200) && (t % 4 != 3);
      do_rd = (t % 4 != 0);
      wr = do_wr ? '1 : '0;
      in = row_val(w);
      rd = do_rd;
      acc = do_rd && (mcnt > 0);
      exp_v = row_val(rrow);
      tick();
      if (acc) begin
        chk($sformatf("t7_row%0d", rrow), out, exp_v);
        rrow++;
        mcnt--;
      end
      if (do_wr) begin
        w++;
        mcnt++;
      end
      chk($sformatf("t7_valid_t%0d", t), W'(o_valid), W'(mcnt > 0));
    end
    wr = '0; rd = 1'b0;
    chk("t7_rows_read", W'(rrow), W'(200));
    chk("t7_ovf", W'(o_overflow), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
